// File: rtl/ca_disrupt_pkg.sv
// Shared constants and state record for the calcium-dynamics / SDSP-condition pipeline.
package ca_disrupt_pkg;

    localparam int unsigned CA_W_DEF   = 3;
    localparam int unsigned LEAK_W_DEF = 5;

    localparam logic [2:0] MODE_FLOOR  = 3'd0;
    localparam logic [2:0] MODE_OSC    = 3'd1;
    localparam logic [2:0] MODE_STEADY = 3'd2;
    localparam logic [2:0] MODE_MULTI  = 3'd3;
    localparam logic [2:0] MODE_SAT    = 3'd4;

    typedef struct packed {
        logic [CA_W_DEF-1:0]   calcium;
        logic [LEAK_W_DEF-1:0] caleak_cnt;
        logic                  osc_dir;
    } ca_state_t;

endpackage

// File: rtl/ca_mode_update.sv
// Combinational neuron-state update: leak tick, calcium per disruption mode,
// oscillation direction and SDSP up/down conditions.
module ca_mode_update
    import ca_disrupt_pkg::*;
#(
    parameter int unsigned CA_W   = 3,
    parameter int unsigned LEAK_W = 5,
    parameter int unsigned MEM_W  = 8,
    parameter int unsigned N_SPK  = 3
) (
    input  logic              param_a_i,
    input  logic [2:0]        param_p_i,
    input  logic [MEM_W-1:0]  thetamem_i,
    input  logic [CA_W-1:0]   theta1_i,
    input  logic [CA_W-1:0]   theta2_i,
    input  logic [CA_W-1:0]   theta3_i,
    input  logic [LEAK_W-1:0] caleak_i,
    input  logic              ca_en_i,
    input  logic [CA_W-1:0]   floor_i,
    input  logic [CA_W-1:0]   ceil_i,
    input  logic [MEM_W-1:0]  core_i,
    input  logic [CA_W-1:0]   calcium_i,
    input  logic [LEAK_W-1:0] caleak_cnt_i,
    input  logic              osc_dir_i,
    input  logic [N_SPK-1:0]  spike_i,
    input  logic              tref_i,
    output logic [CA_W-1:0]   calcium_c_o,
    output logic [LEAK_W-1:0] caleak_cnt_c_o,
    output logic              osc_dir_c_o,
    output logic              v_up_c_o,
    output logic              v_down_c_o
);

    localparam int unsigned PW = $clog2(N_SPK + 1);
    localparam int unsigned SW = ((CA_W > PW) ? CA_W : PW) + 1;
    localparam logic [CA_W-1:0] CA_MAX = '1;

    logic              leak;
    logic [LEAK_W-1:0] cnt_n;
    logic [CA_W-1:0]   ca_n;
    logic              dir_n;
    logic [PW-1:0]     pop;
    logic [SW-1:0]     sum;
    logic [CA_W-1:0]   dec_lim;
    logic [CA_W-1:0]   lo;
    logic              spk0;

    assign spk0 = spike_i[0];
    assign pop  = PW'($countones(spike_i));

    // Leak counter; >= rather than == pulls an out-of-range count back to zero
    always_comb begin
        leak  = 1'b0;
        cnt_n = caleak_cnt_i;
        if (ca_en_i && (caleak_i != '0) && tref_i) begin
            if (caleak_cnt_i >= (caleak_i - LEAK_W'(1))) begin
                cnt_n = '0;
                leak  = 1'b1;
            end else begin
                cnt_n = caleak_cnt_i + LEAK_W'(1);
            end
        end
    end

    always_comb begin
        ca_n    = calcium_i;
        dir_n   = osc_dir_i;
        dec_lim = (param_a_i && (param_p_i == MODE_FLOOR)) ? floor_i : '0;
        sum     = SW'(calcium_i) + SW'(pop);
        if (leak && (sum != '0)) begin
            sum = sum - SW'(1);
        end

        if (!param_a_i || (param_p_i == MODE_SAT) || (param_p_i == MODE_FLOOR)) begin
            if (spk0 && !leak && (calcium_i != CA_MAX)) begin
                ca_n = calcium_i + CA_W'(1);
            end else if (!spk0 && leak && (calcium_i > dec_lim)) begin
                ca_n = calcium_i - CA_W'(1);
            end
        end else begin
            case (param_p_i)
                MODE_OSC: begin
                    if (calcium_i < floor_i) begin
                        ca_n  = floor_i;
                        dir_n = 1'b1;
                    end else if (calcium_i > ceil_i) begin
                        ca_n  = ceil_i;
                        dir_n = 1'b0;
                    end else if (leak) begin
                        if (osc_dir_i) begin
                            if (calcium_i < ceil_i) ca_n = calcium_i + CA_W'(1);
                        end else begin
                            if (calcium_i > floor_i) ca_n = calcium_i - CA_W'(1);
                        end
                        if (ca_n == ceil_i) begin
                            dir_n = 1'b0;
                        end else if (ca_n == floor_i) begin
                            dir_n = 1'b1;
                        end
                    end
                end
                MODE_STEADY: begin
                    if (spk0 && (calcium_i < ceil_i)) ca_n = calcium_i + CA_W'(1);
                end
                MODE_MULTI: begin
                    if (sum < SW'(floor_i)) begin
                        ca_n = floor_i;
                    end else if (sum > SW'(ceil_i)) begin
                        ca_n = ceil_i;
                    end else begin
                        ca_n = CA_W'(sum);
                    end
                end
                default: ;
            endcase
        end
    end

    assign lo             = param_a_i ? (theta1_i >> 1) : theta1_i;
    assign calcium_c_o    = ca_n;
    assign caleak_cnt_c_o = cnt_n;
    assign osc_dir_c_o    = dir_n;
    assign v_up_c_o       = ca_en_i && (core_i >= thetamem_i) && (lo <= ca_n) && (ca_n < theta3_i);
    assign v_down_c_o     = ca_en_i && (core_i < thetamem_i) && (lo <= ca_n) && (ca_n < theta2_i);

endmodule

// File: rtl/ca_disrupt_pipe.sv
// Two-stage valid/ready wrapper around ca_mode_update with read-after-write
// bypass from the output register and the last handed-off result.
module ca_disrupt_pipe
    import ca_disrupt_pkg::*;
#(
    parameter int unsigned CA_W   = 3,
    parameter int unsigned LEAK_W = 5,
    parameter int unsigned MEM_W  = 8,
    parameter int unsigned N_SPK  = 3,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              param_a,
    input  logic [2:0]        param_p,
    input  logic [MEM_W-1:0]  param_thetamem,
    input  logic [CA_W-1:0]   param_ca_theta1,
    input  logic [CA_W-1:0]   param_ca_theta2,
    input  logic [CA_W-1:0]   param_ca_theta3,
    input  logic [LEAK_W-1:0] param_caleak,
    input  logic              param_ca_en,
    input  logic [CA_W-1:0]   param_ca_floor,
    input  logic [CA_W-1:0]   param_ca_ceil,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [MEM_W-1:0]  in_core_next,
    input  logic [CA_W-1:0]   in_calcium,
    input  logic [LEAK_W-1:0] in_caleak_cnt,
    input  logic              in_osc_dir,
    input  logic [N_SPK-1:0]  in_spike,
    input  logic              in_event_tref,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CA_W-1:0]   out_calcium,
    output logic [LEAK_W-1:0] out_caleak_cnt,
    output logic              out_osc_dir,
    output logic              out_v_up,
    output logic              out_v_down
);

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [MEM_W-1:0]  s1_core_q;
    logic [CA_W-1:0]   s1_ca_q;
    logic [LEAK_W-1:0] s1_cnt_q;
    logic              s1_dir_q;
    logic [N_SPK-1:0]  s1_spike_q;
    logic              s1_tref_q;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [CA_W-1:0]   out_ca_q, out_ca_d;
    logic [LEAK_W-1:0] out_cnt_q, out_cnt_d;
    logic              out_dir_q, out_dir_d;
    logic              out_up_q, out_up_d;
    logic              out_down_q, out_down_d;

    logic              lw_valid_q, lw_valid_d;
    logic [ADDR_W-1:0] lw_addr_q;
    logic [CA_W-1:0]   lw_ca_q;
    logic [LEAK_W-1:0] lw_cnt_q;
    logic              lw_dir_q;

    logic              out_load, s1_load, out_fire;
    logic [CA_W-1:0]   byp_ca;
    logic [LEAK_W-1:0] byp_cnt;
    logic              byp_dir;

    assign out_load    = !out_valid_q || out_ready;
    assign s1_load     = !s1_valid_q || out_load;
    assign out_fire    = out_valid_q && out_ready;
    assign s1_valid_d  = s1_load ? in_valid : s1_valid_q;
    assign out_valid_d = out_load ? s1_valid_q : out_valid_q;
    assign lw_valid_d  = lw_valid_q || out_fire;

    // Newest copy of the neuron state wins: output register, then last handed-off
    always_comb begin
        byp_ca  = s1_ca_q;
        byp_cnt = s1_cnt_q;
        byp_dir = s1_dir_q;
        if (out_valid_q && (out_addr_q == s1_addr_q)) begin
            byp_ca  = out_ca_q;
            byp_cnt = out_cnt_q;
            byp_dir = out_dir_q;
        end else if (lw_valid_q && (lw_addr_q == s1_addr_q)) begin
            byp_ca  = lw_ca_q;
            byp_cnt = lw_cnt_q;
            byp_dir = lw_dir_q;
        end
    end

    ca_mode_update #(
        .CA_W   (CA_W),
        .LEAK_W (LEAK_W),
        .MEM_W  (MEM_W),
        .N_SPK  (N_SPK)
    ) u_update (
        .param_a_i      (param_a),
        .param_p_i      (param_p),
        .thetamem_i     (param_thetamem),
        .theta1_i       (param_ca_theta1),
        .theta2_i       (param_ca_theta2),
        .theta3_i       (param_ca_theta3),
        .caleak_i       (param_caleak),
        .ca_en_i        (param_ca_en),
        .floor_i        (param_ca_floor),
        .ceil_i         (param_ca_ceil),
        .core_i         (s1_core_q),
        .calcium_i      (byp_ca),
        .caleak_cnt_i   (byp_cnt),
        .osc_dir_i      (byp_dir),
        .spike_i        (s1_spike_q),
        .tref_i         (s1_tref_q),
        .calcium_c_o    (out_ca_d),
        .caleak_cnt_c_o (out_cnt_d),
        .osc_dir_c_o    (out_dir_d),
        .v_up_c_o       (out_up_d),
        .v_down_c_o     (out_down_d)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_core_q   <= '0;
            s1_ca_q     <= '0;
            s1_cnt_q    <= '0;
            s1_dir_q    <= 1'b0;
            s1_spike_q  <= '0;
            s1_tref_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_ca_q    <= '0;
            out_cnt_q   <= '0;
            out_dir_q   <= 1'b0;
            out_up_q    <= 1'b0;
            out_down_q  <= 1'b0;
            lw_valid_q  <= 1'b0;
            lw_addr_q   <= '0;
            lw_ca_q     <= '0;
            lw_cnt_q    <= '0;
            lw_dir_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            lw_valid_q  <= lw_valid_d;
            if (s1_load && in_valid) begin
                s1_addr_q  <= in_addr;
                s1_core_q  <= in_core_next;
                s1_ca_q    <= in_calcium;
                s1_cnt_q   <= in_caleak_cnt;
                s1_dir_q   <= in_osc_dir;
                s1_spike_q <= in_spike;
                s1_tref_q  <= in_event_tref;
            end
            if (out_load && s1_valid_q) begin
                out_addr_q <= s1_addr_q;
                out_ca_q   <= out_ca_d;
                out_cnt_q  <= out_cnt_d;
                out_dir_q  <= out_dir_d;
                out_up_q   <= out_up_d;
                out_down_q <= out_down_d;
            end
            if (out_fire) begin
                lw_addr_q <= out_addr_q;
                lw_ca_q   <= out_ca_q;
                lw_cnt_q  <= out_cnt_q;
                lw_dir_q  <= out_dir_q;
            end
        end
    end

    assign in_ready       = s1_load;
    assign out_valid      = out_valid_q;
    assign out_addr       = out_addr_q;
    assign out_calcium    = out_ca_q;
    assign out_caleak_cnt = out_cnt_q;
    assign out_osc_dir    = out_dir_q;
    assign out_v_up       = out_up_q;
    assign out_v_down     = out_down_q;

endmodule

// File: tb/tb_ca_disrupt_pipe.sv
// Randomised and directed bench for ca_disrupt_pipe against a plain-integer reference model.
module tb_ca_disrupt_pipe;
    import ca_disrupt_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       param_a, param_ca_en;
    logic [2:0] param_p;
    logic [7:0] param_thetamem;
    logic [2:0] param_ca_theta1, param_ca_theta2, param_ca_theta3;
    logic [4:0] param_caleak;
    logic [2:0] param_ca_floor, param_ca_ceil;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_addr, in_core_next;
    logic [2:0] in_calcium;
    logic [4:0] in_caleak_cnt;
    logic       in_osc_dir, in_event_tref;
    logic [2:0] in_spike;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_addr;
    logic [2:0] out_calcium;
    logic [4:0] out_caleak_cnt;
    logic       out_osc_dir, out_v_up, out_v_down;

    ca_disrupt_pipe dut (
        .CLK(CLK), .RST(RST),
        .param_a(param_a), .param_p(param_p), .param_thetamem(param_thetamem),
        .param_ca_theta1(param_ca_theta1), .param_ca_theta2(param_ca_theta2),
        .param_ca_theta3(param_ca_theta3), .param_caleak(param_caleak),
        .param_ca_en(param_ca_en), .param_ca_floor(param_ca_floor), .param_ca_ceil(param_ca_ceil),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_core_next(in_core_next),
        .in_calcium(in_calcium), .in_caleak_cnt(in_caleak_cnt), .in_osc_dir(in_osc_dir),
        .in_spike(in_spike), .in_event_tref(in_event_tref),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_calcium(out_calcium), .out_caleak_cnt(out_caleak_cnt), .out_osc_dir(out_osc_dir),
        .out_v_up(out_v_up), .out_v_down(out_v_down)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] core;
        logic [2:0] ca;
        logic [4:0] cnt;
        logic       dir;
        logic [2:0] spike;
        logic       tref;
        logic       chk;
        logic [2:0] x_ca;
        logic [4:0] x_cnt;
        logic       x_dir;
        logic       x_up;
        logic       x_down;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [2:0] ca;
        logic [4:0] cnt;
        logic       dir;
        logic       up;
        logic       down;
        logic       lat;
        int         icyc;
    } exp_t;

    stim_t     stim_q[$];
    exp_t      exp_q[$];
    stim_t     cur;
    logic      cur_v = 1'b0;
    logic      gap_en = 1'b0, rdy_force = 1'b1, rdy_val = 1'b1;
    int        n_vec = 0, n_err = 0, cyc = 0, acc_cnt = 0;
    logic      m_prev_v = 1'b0;
    logic [7:0] m_prev_addr;
    ca_state_t m_prev_st;
    logic      g_p_v = 1'b0, g_p2_v = 1'b0;
    logic [7:0] g_p, g_p2;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic [7:0] addr, input logic [7:0] core, input logic [2:0] ca,
                                 input logic [4:0] cnt, input logic dir, input logic [2:0] spike,
                                 input logic tref);
        stim_t s;
        s = '0;
        s.addr = addr; s.core = core; s.ca = ca; s.cnt = cnt;
        s.dir = dir; s.spike = spike; s.tref = tref;
        return s;
    endfunction

    function automatic stim_t mkx(input stim_t s, input logic [2:0] xca, input logic [4:0] xcnt,
                                  input logic xdir, input logic xup, input logic xdown);
        stim_t r;
        r = s;
        r.chk = 1'b1; r.x_ca = xca; r.x_cnt = xcnt; r.x_dir = xdir; r.x_up = xup; r.x_down = xdown;
        return r;
    endfunction

    // Reference: state follows the immediately preceding transaction to the same neuron
    task automatic accept(input stim_t s);
        exp_t e;
        int ca, cnt, dir, lk, pc, fl, cl, lo, mode;
        if (m_prev_v && m_prev_addr == s.addr) begin
            ca = int'(m_prev_st.calcium); cnt = int'(m_prev_st.caleak_cnt); dir = int'(m_prev_st.osc_dir);
        end else begin
            ca = int'(s.ca); cnt = int'(s.cnt); dir = int'(s.dir);
        end
        fl = int'(param_ca_floor); cl = int'(param_ca_ceil);
        lk = 0;
        if (param_ca_en && param_caleak != 0 && s.tref) begin
            if (cnt >= int'(param_caleak) - 1) begin cnt = 0; lk = 1; end
            else cnt = cnt + 1;
        end
        pc   = $countones(s.spike);
        mode = param_a ? int'(param_p) : 4;
        case (mode)
            0, 4: begin
                if (s.spike[0] && lk == 0 && ca < 7) ca = ca + 1;
                else if (!s.spike[0] && lk == 1 && ca > ((mode == 0) ? fl : 0)) ca = ca - 1;
            end
            1: begin
                if (ca < fl) begin ca = fl; dir = 1; end
                else if (ca > cl) begin ca = cl; dir = 0; end
                else if (lk == 1) begin
                    if (dir == 1) ca = (ca + 1 > cl) ? cl : ca + 1;
                    else          ca = (ca - 1 < fl) ? fl : ca - 1;
                    if (ca == cl) dir = 0;
                    else if (ca == fl) dir = 1;
                end
            end
            2: if (s.spike[0] && ca < cl) ca = ca + 1;
            3: begin
                ca = ca + pc - lk;
                if (ca < fl) ca = fl;
                if (ca > cl) ca = cl;
            end
            default: ;
        endcase
        lo = param_a ? int'(param_ca_theta1) / 2 : int'(param_ca_theta1);
        e.s    = s;
        e.ca   = 3'(ca);
        e.cnt  = 5'(cnt);
        e.dir  = 1'(dir);
        e.up   = param_ca_en && s.core >= param_thetamem && lo <= ca && ca < int'(param_ca_theta3);
        e.down = param_ca_en && s.core < param_thetamem && lo <= ca && ca < int'(param_ca_theta2);
        e.lat  = s.chk && rdy_force && rdy_val;
        e.icyc = cyc;
        exp_q.push_back(e);
        m_prev_v = 1'b1;
        m_prev_addr = s.addr;
        m_prev_st.calcium = e.ca; m_prev_st.caleak_cnt = e.cnt; m_prev_st.osc_dir = e.dir;
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("spurious_out", 32'(out_valid), 0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("addr", 32'(out_addr), 32'(e.s.addr));
        check_eq("calcium", 32'(out_calcium), 32'(e.ca));
        check_eq("caleak_cnt", 32'(out_caleak_cnt), 32'(e.cnt));
        check_eq("osc_dir", 32'(out_osc_dir), 32'(e.dir));
        check_eq("v_up", 32'(out_v_up), 32'(e.up));
        check_eq("v_down", 32'(out_v_down), 32'(e.down));
        if (e.s.chk) begin
            check_eq("dir_calcium", 32'(out_calcium), 32'(e.s.x_ca));
            check_eq("dir_cnt", 32'(out_caleak_cnt), 32'(e.s.x_cnt));
            check_eq("dir_osc", 32'(out_osc_dir), 32'(e.s.x_dir));
            check_eq("dir_v_up", 32'(out_v_up), 32'(e.s.x_up));
            check_eq("dir_v_down", 32'(out_v_down), 32'(e.s.x_down));
        end
        if (e.lat) check_eq("latency", 32'(cyc - e.icyc), 2);
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
        if (!cur_v && stim_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            cur = stim_q.pop_front();
            cur_v = 1'b1;
        end
        in_valid = cur_v;
        in_addr = cur.addr; in_core_next = cur.core; in_calcium = cur.ca;
        in_caleak_cnt = cur.cnt; in_osc_dir = cur.dir; in_spike = cur.spike; in_event_tref = cur.tref;
        out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) check_out();
        if (in_valid && in_ready) begin
            accept(cur);
            cur_v = 1'b0;
            acc_cnt++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (stim_q.size() == 0 && !cur_v && exp_q.size() == 0) break;
            step();
        end
        check_eq("drain", 32'(stim_q.size() + exp_q.size()) + 32'(cur_v), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0; cur_v = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        stim_q.delete();
        m_prev_v = 1'b0; g_p_v = 1'b0; g_p2_v = 1'b0;
    endtask

    task automatic set_params(input logic a, input logic [2:0] p, input logic [2:0] fl, input logic [2:0] cl,
                              input logic [4:0] leak, input logic [2:0] t1, input logic [2:0] t2,
                              input logic [2:0] t3, input logic [7:0] thm);
        param_a = a; param_p = p; param_ca_floor = fl; param_ca_ceil = cl; param_caleak = leak;
        param_ca_theta1 = t1; param_ca_theta2 = t2; param_ca_theta3 = t3; param_thetamem = thm;
        param_ca_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        cur = '0;
        set_params(1'b0, 3'd0, 3'd0, 3'd7, 5'd4, 3'd2, 3'd4, 3'd6, 8'd100);
        do_reset();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_addr", 32'(out_addr), 0);
        check_eq("rst_calcium", 32'(out_calcium), 0);
        check_eq("rst_cnt", 32'(out_caleak_cnt), 0);
        check_eq("rst_dir", 32'(out_osc_dir), 0);
        check_eq("rst_up", 32'(out_v_up), 0);
        check_eq("rst_down", 32'(out_v_down), 0);

        // Healthy saturation at MAX and leak decrement with counter wrap
        rdy_force = 1'b1; rdy_val = 1'b1; gap_en = 1'b0;
        stim_q.push_back(mkx(mk(8'h01, 8'd50, 3'd7, 5'd0, 1'b0, 3'b001, 1'b0), 3'd7, 5'd0, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(mkx(mk(8'h02, 8'd150, 3'd5, 5'd3, 1'b1, 3'b000, 1'b1), 3'd4, 5'd0, 1'b1, 1'b1, 1'b0));
        drain();

        // Oscillation on one neuron, later inputs deliberately stale to require bypass
        set_params(1'b1, MODE_OSC, 3'd1, 3'd3, 5'd1, 3'd2, 3'd4, 3'd6, 8'd100);
        stim_q.push_back(mkx(mk(8'h20, 8'd50, 3'd1, 5'd0, 1'b1, 3'b000, 1'b1), 3'd2, 5'd0, 1'b1, 1'b0, 1'b1));
        stim_q.push_back(mkx(mk(8'h20, 8'd50, 3'd0, 5'd5, 1'b0, 3'b111, 1'b1), 3'd3, 5'd0, 1'b0, 1'b0, 1'b1));
        stim_q.push_back(mkx(mk(8'h20, 8'd50, 3'd0, 5'd5, 1'b0, 3'b000, 1'b1), 3'd2, 5'd0, 1'b0, 1'b0, 1'b1));
        stim_q.push_back(mkx(mk(8'h20, 8'd50, 3'd0, 5'd5, 1'b0, 3'b001, 1'b1), 3'd1, 5'd0, 1'b1, 1'b0, 1'b1));
        stim_q.push_back(mkx(mk(8'h20, 8'd50, 3'd0, 5'd5, 1'b0, 3'b000, 1'b1), 3'd2, 5'd0, 1'b1, 1'b0, 1'b1));
        stim_q.push_back(mkx(mk(8'h20, 8'd50, 3'd0, 5'd5, 1'b0, 3'b000, 1'b1), 3'd3, 5'd0, 1'b0, 1'b0, 1'b1));
        drain();

        // Multi-input: leak offsets popcount, then saturate at ceil
        set_params(1'b1, MODE_MULTI, 3'd0, 3'd6, 5'd1, 3'd2, 3'd4, 3'd6, 8'd100);
        stim_q.push_back(mkx(mk(8'h30, 8'd50, 3'd2, 5'd0, 1'b0, 3'b111, 1'b1), 3'd4, 5'd0, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(mkx(mk(8'h31, 8'd50, 3'd5, 5'd2, 1'b1, 3'b111, 1'b0), 3'd6, 5'd2, 1'b1, 1'b0, 1'b0));
        drain();

        // Backpressure with SDSP thresholds around theta1>>1 and theta3
        set_params(1'b1, MODE_SAT, 3'd0, 3'd7, 5'd1, 3'd4, 3'd6, 3'd5, 8'd100);
        rdy_val = 1'b0; acc_cnt = 0;
        stim_q.push_back(mkx(mk(8'h40, 8'd100, 3'd3, 5'd0, 1'b0, 3'b000, 1'b0), 3'd3, 5'd0, 1'b0, 1'b1, 1'b0));
        stim_q.push_back(mkx(mk(8'h41, 8'd100, 3'd4, 5'd0, 1'b0, 3'b000, 1'b0), 3'd4, 5'd0, 1'b0, 1'b1, 1'b0));
        stim_q.push_back(mkx(mk(8'h42, 8'd100, 3'd1, 5'd0, 1'b0, 3'b000, 1'b0), 3'd1, 5'd0, 1'b0, 1'b0, 1'b0));
        repeat (5) step();
        check_eq("bp_accepted", 32'(acc_cnt), 2);
        check_eq("bp_in_ready", 32'(in_ready), 0);
        check_eq("bp_out_valid", 32'(out_valid), 1);
        check_eq("bp_hold_addr", 32'(out_addr), 32'h40);
        check_eq("bp_hold_ca", 32'(out_calcium), 3);
        rdy_val = 1'b1;
        drain();

        // Reset while a transaction sits in S1 must drop it silently
        stim_q.push_back(mk(8'h50, 8'd10, 3'd2, 5'd0, 1'b0, 3'b001, 1'b0));
        step();
        do_reset();
        repeat (4) step();
        check_eq("drop_quiet", 32'(out_valid), 0);

        // Randomised phases: parameters change only with the pipe empty
        for (int ph = 0; ph < 12; ph++) begin
            logic [2:0] fl;
            fl = 3'($urandom_range(0, 5));
            set_params(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), fl,
                       3'($urandom_range(int'(fl) + 1, 7)), 5'($urandom_range(0, 6)),
                       3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            param_ca_en = ($urandom_range(0, 7) != 0);
            gap_en = 1'b1; rdy_force = (ph % 4 == 3);
            for (int k = 0; k < 30; k++) begin
                stim_t s;
                logic [7:0] a;
                a = 8'($urandom_range(0, 5));
                if (g_p2_v && a == g_p2 && !(g_p_v && a == g_p)) a = g_p;
                g_p2 = g_p; g_p2_v = g_p_v; g_p = a; g_p_v = 1'b1;
                s = mk(a, 8'($urandom), 3'($urandom), 5'($urandom), 1'($urandom),
                       3'($urandom), 1'($urandom_range(0, 3) != 0));
                stim_q.push_back(s);
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
